// File: rtl/datapath_pkg.sv
// datapath_pkg: shared types for the parametrised datapath.
//   alu_op_e : ALU operation encoding driven by the control unit
//   wb_sel_e : write-back source select
//   flags_t  : status flags {z,n,c,v}
//   state_e  : multiplier sequencing FSM states
package datapath_pkg;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_AND   = 3'b010,
    ALU_OR    = 3'b011,
    ALU_XOR   = 3'b100,
    ALU_PASSA = 3'b101,
    ALU_SHL1  = 3'b110,
    ALU_MUL   = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_DM   = 2'b01,
    WB_IMMZ = 2'b10,
    WB_IMMS = 2'b11
  } wb_sel_e;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flags_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    WB   = 2'b10
  } state_e;

endpackage

// File: rtl/datapath_if.sv
// datapath_if: operation-issue bus between the control unit (master) and
// the datapath (slave).
//   op_valid/op_ready : issue handshake
//   alu_op, wb_sel    : operation and write-back source
//   W_addr/W_wr       : write port
//   Rp_*/Rq_*         : read port addresses and read enables
//   imm               : immediate operand
//
// Handshake: an operation transfers on a rising edge where op_valid and
// op_ready are both 1. The master holds all fields stable while op_valid=1
// and op_ready=0; op_ready does not depend on op_valid.
interface datapath_if #(
  parameter int AW = 4,
  parameter int IW = 8
);
  logic          op_valid;
  logic          op_ready;
  logic [2:0]    alu_op;
  logic [1:0]    wb_sel;
  logic [AW-1:0] W_addr;
  logic          W_wr;
  logic [AW-1:0] Rp_addr;
  logic          Rp_rd;
  logic [AW-1:0] Rq_addr;
  logic          Rq_rd;
  logic [IW-1:0] imm;

  modport master (
    output op_valid, alu_op, wb_sel, W_addr, W_wr, Rp_addr, Rp_rd,
           Rq_addr, Rq_rd, imm,
    input  op_ready
  );

  modport slave (
    input  op_valid, alu_op, wb_sel, W_addr, W_wr, Rp_addr, Rp_rd,
           Rq_addr, Rq_rd, imm,
    output op_ready
  );
endinterface

// File: rtl/datapath_param_rf.sv
// rf_param: NREGS x DW register file, one write port, two gated read ports.
//   clk, rst        : clock, asynchronous active-low clear
//   we/waddr/wdata  : write port, written at the rising edge
//   rd_p/ra_p/data_p: read port P, data = rd_p ? RF[ra_p] : 0
//   rd_q/ra_q/data_q: read port Q, same behaviour
// Reads are combinational and see the pre-edge contents (no bypass).
module rf_param #(
  parameter int DW    = 16,
  parameter int NREGS = 16,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          rd_p,
  input  logic [AW-1:0] ra_p,
  output logic [DW-1:0] data_p,
  input  logic          rd_q,
  input  logic [AW-1:0] ra_q,
  output logic [DW-1:0] data_q
);

  logic [DW-1:0] rf_q [NREGS];
  logic [DW-1:0] rf_d [NREGS];

  always_comb begin
    rf_d = rf_q;
    if (we) rf_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rf_q <= '{default: '0};
    else      rf_q <= rf_d;
  end

  assign data_p = rd_p ? rf_q[ra_p] : '0;
  assign data_q = rd_q ? rf_q[ra_q] : '0;

endmodule

// File: rtl/datapath_param.sv
// datapath_param: register file + ALU with a DW-cycle shift-add multiplier,
// four-way write-back mux and registered status flags.
//   clk, rst   : clock, asynchronous active-low reset
//   bus        : operation-issue interface (slave side)
//   DM_Din     : data memory read data (write-back source 01)
//   Rp_data    : port-P read data, also the data memory address/data
//   Rp_zero    : Rp_data == 0
//   flags      : registered {Z,N,C,V}
//   done       : 1 in the multiplier write-back cycle
//   dbg_state  : current multiplier FSM state
module datapath_param
  import datapath_pkg::*;
#(
  parameter int DW    = 16,
  parameter int NREGS = 16,
  parameter int AW    = $clog2(NREGS),
  parameter int IW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  datapath_if.slave     bus,
  input  logic [DW-1:0] DM_Din,
  output logic [DW-1:0] Rp_data,
  output logic          Rp_zero,
  output logic [3:0]    flags,
  output logic          done,
  output state_e        dbg_state
);

  localparam int CW = $clog2(DW);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*DW-1:0] mcand_q, mcand_d;
  logic [DW-1:0]   mplier_q, mplier_d;
  logic [2*DW-1:0] prod_q, prod_d;
  logic [AW-1:0]   dst_addr_q, dst_addr_d;
  logic            dst_wr_q, dst_wr_d;
  flags_t          flags_q, flags_d;

  logic [DW-1:0]   rq_data;
  logic            rf_we;
  logic [AW-1:0]   rf_waddr;
  logic [DW-1:0]   rf_wdata;
  logic [DW-1:0]   wb_data;
  logic [DW-1:0]   alu_res;
  logic            alu_c, alu_v;
  logic [DW:0]     add_w, sub_w;
  logic            op_ready_w;

  rf_param #(.DW(DW), .NREGS(NREGS), .AW(AW)) u_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (rf_we),
    .waddr  (rf_waddr),
    .wdata  (rf_wdata),
    .rd_p   (bus.Rp_rd),
    .ra_p   (bus.Rp_addr),
    .data_p (Rp_data),
    .rd_q   (bus.Rq_rd),
    .ra_q   (bus.Rq_addr),
    .data_q (rq_data)
  );

  // Extra top bit of the subtraction is the borrow (A < B unsigned).
  assign add_w = {1'b0, Rp_data} + {1'b0, rq_data};
  assign sub_w = {1'b0, Rp_data} - {1'b0, rq_data};

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (bus.alu_op)
      ALU_ADD: begin
        alu_res = add_w[DW-1:0];
        alu_c   = add_w[DW];
        alu_v   = (Rp_data[DW-1] == rq_data[DW-1]) && (add_w[DW-1] != Rp_data[DW-1]);
      end
      ALU_SUB: begin
        alu_res = sub_w[DW-1:0];
        alu_c   = sub_w[DW];
        alu_v   = (Rp_data[DW-1] != rq_data[DW-1]) && (sub_w[DW-1] != Rp_data[DW-1]);
      end
      ALU_AND:   alu_res = Rp_data & rq_data;
      ALU_OR:    alu_res = Rp_data | rq_data;
      ALU_XOR:   alu_res = Rp_data ^ rq_data;
      ALU_PASSA: alu_res = Rp_data;
      ALU_SHL1: begin
        alu_res = {Rp_data[DW-2:0], 1'b0};
        alu_c   = Rp_data[DW-1];
      end
      // MUL never completes in one cycle; its result comes from prod_q.
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    wb_data = alu_res;
    case (bus.wb_sel)
      WB_ALU:  wb_data = alu_res;
      WB_DM:   wb_data = DM_Din;
      WB_IMMZ: wb_data = {{(DW-IW){1'b0}}, bus.imm};
      default: wb_data = {{(DW-IW){bus.imm[IW-1]}}, bus.imm};
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    prod_d     = prod_q;
    dst_addr_d = dst_addr_q;
    dst_wr_d   = dst_wr_q;
    flags_d    = flags_q;
    rf_we      = 1'b0;
    rf_waddr   = bus.W_addr;
    rf_wdata   = wb_data;
    op_ready_w = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        op_ready_w = 1'b1;
        if (bus.op_valid) begin
          if (bus.wb_sel == WB_ALU && bus.alu_op == ALU_MUL) begin
            mcand_d    = {{DW{1'b0}}, Rp_data};
            mplier_d   = rq_data;
            prod_d     = '0;
            cnt_d      = '0;
            dst_addr_d = bus.W_addr;
            dst_wr_d   = bus.W_wr;
            state_d    = MUL;
          end else begin
            rf_we = bus.W_wr;
            // ALU ops update flags even without a write (compare via SUB).
            if (bus.wb_sel == WB_ALU) begin
              flags_d = '{z: (alu_res == '0), n: alu_res[DW-1], c: alu_c, v: alu_v};
            end
          end
        end
      end
      MUL: begin
        // Consume one multiplier bit per cycle, LSB first.
        if (mplier_q[0]) prod_d = prod_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(DW - 1)) state_d = WB;
      end
      WB: begin
        done     = 1'b1;
        rf_we    = dst_wr_q;
        rf_waddr = dst_addr_q;
        rf_wdata = prod_q[DW-1:0];
        flags_d  = '{z: (prod_q[DW-1:0] == '0), n: prod_q[DW-1],
                     c: |prod_q[2*DW-1:DW], v: 1'b0};
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      prod_q     <= '0;
      dst_addr_q <= '0;
      dst_wr_q   <= 1'b0;
      flags_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      prod_q     <= prod_d;
      dst_addr_q <= dst_addr_d;
      dst_wr_q   <= dst_wr_d;
      flags_q    <= flags_d;
    end
  end

  assign bus.op_ready = op_ready_w;
  assign Rp_zero      = ~|Rp_data;
  assign flags        = flags_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_datapath_param.sv
// tb_datapath_param: directed test of datapath_param (DW=16, NREGS=16, IW=8).
module tb_datapath_param;
  import datapath_pkg::*;

  logic        clk;
  logic        rst;
  logic [15:0] DM_Din;
  logic [15:0] Rp_data;
  logic        Rp_zero;
  logic [3:0]  flags;
  logic        done;
  state_e      dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  datapath_if #(.AW(4), .IW(8)) bus ();

  datapath_param #(.DW(16), .NREGS(16), .IW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .DM_Din    (DM_Din),
    .Rp_data   (Rp_data),
    .Rp_zero   (Rp_zero),
    .flags     (flags),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reg(input string tag, input logic [3:0] a, input logic [15:0] exp);
    bus.Rp_addr = a;
    bus.Rp_rd   = 1'b1;
    #1;
    check(tag, {16'h0, Rp_data}, {16'h0, exp});
  endtask

  // driver: present one op for exactly one accepting edge (caller is in IDLE)
  task automatic issue(input logic [2:0] op, input logic [1:0] ws, input logic [3:0] wa,
                       input logic wr, input logic [3:0] pa, input logic [3:0] qa,
                       input logic [7:0] im, input logic [15:0] din);
    bus.op_valid = 1'b1;
    bus.alu_op   = op;
    bus.wb_sel   = ws;
    bus.W_addr   = wa;
    bus.W_wr     = wr;
    bus.Rp_addr  = pa;
    bus.Rp_rd    = 1'b1;
    bus.Rq_addr  = qa;
    bus.Rq_rd    = 1'b1;
    bus.imm      = im;
    DM_Din       = din;
    step(1);
    bus.op_valid = 1'b0;
    bus.W_wr     = 1'b0;
  endtask

  initial begin
    int done_seen;
    rst = 1'b0;
    bus.op_valid = 1'b0; bus.alu_op = 3'd0; bus.wb_sel = 2'd0;
    bus.W_addr = 4'd0; bus.W_wr = 1'b0; bus.Rp_addr = 4'd0; bus.Rp_rd = 1'b1;
    bus.Rq_addr = 4'd0; bus.Rq_rd = 1'b1; bus.imm = 8'd0; DM_Din = 16'd0;
    step(2);
    rst = 1'b1;
    step(1);

    // reset state
    check("rst_ready", {31'd0, bus.op_ready}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_flags", {28'd0, flags}, 32'd0);
    check("rst_rp", {16'd0, Rp_data}, 32'd0);
    check("rst_rpzero", {31'd0, Rp_zero}, 32'd1);
    check("rst_state", {30'd0, dbg_state}, {30'd0, IDLE});

    // zero-extended imm, with no-bypass read before the edge
    bus.op_valid = 1'b1; bus.alu_op = 3'd0; bus.wb_sel = 2'b10; bus.imm = 8'h80;
    bus.W_addr = 4'd1; bus.W_wr = 1'b1; bus.Rp_addr = 4'd1; bus.Rp_rd = 1'b1;
    #1;
    check("nobypass", {16'd0, Rp_data}, 32'd0);
    step(1);
    bus.op_valid = 1'b0; bus.W_wr = 1'b0;
    check_reg("immz_r1", 4'd1, 16'h0080);
    check("immz_flags", {28'd0, flags}, 32'd0);

    // sign-extended imm
    issue(3'd0, 2'b11, 4'd2, 1'b1, 4'd0, 4'd0, 8'h80, 16'h0);
    check_reg("imms_r2", 4'd2, 16'hFF80);
    check("imms_flags", {28'd0, flags}, 32'd0);

    // gated read port
    bus.Rp_addr = 4'd2; bus.Rp_rd = 1'b0;
    #1;
    check("gated_rp", {16'd0, Rp_data}, 32'd0);
    check("gated_zero", {31'd0, Rp_zero}, 32'd1);

    // ADD wrap: 0xFFFF + 0x0001
    issue(3'd0, 2'b01, 4'd1, 1'b1, 4'd0, 4'd0, 8'h00, 16'hFFFF);
    issue(3'd0, 2'b10, 4'd2, 1'b1, 4'd0, 4'd0, 8'h01, 16'h0);
    issue(3'b000, 2'b00, 4'd3, 1'b1, 4'd1, 4'd2, 8'h00, 16'h0);
    check_reg("add_r3", 4'd3, 16'h0000);
    check("add_flags", {28'd0, flags}, 32'hA);

    // DM write leaves flags; SUB compare with no write
    issue(3'd0, 2'b01, 4'd7, 1'b1, 4'd0, 4'd0, 8'h00, 16'h8000);
    check("dm_flags", {28'd0, flags}, 32'hA);
    issue(3'b001, 2'b00, 4'd9, 1'b0, 4'd7, 4'd2, 8'h00, 16'h0);
    check_reg("sub_nowrite", 4'd9, 16'h0000);
    check("sub_flags", {28'd0, flags}, 32'h1);

    // XOR 0x8000 ^ 0xFFFF
    issue(3'b100, 2'b00, 4'd8, 1'b1, 4'd7, 4'd1, 8'h00, 16'h0);
    check_reg("xor_r8", 4'd8, 16'h7FFF);
    check("xor_flags", {28'd0, flags}, 32'h0);

    // MUL 0x12 * 0x34 with a held write op as backpressure
    issue(3'd0, 2'b10, 4'd4, 1'b1, 4'd0, 4'd0, 8'h12, 16'h0);
    issue(3'd0, 2'b10, 4'd5, 1'b1, 4'd0, 4'd0, 8'h34, 16'h0);
    issue(3'b111, 2'b00, 4'd6, 1'b1, 4'd4, 4'd5, 8'h00, 16'h0);
    check("mul_busy", {31'd0, bus.op_ready}, 32'd0);
    check("mul_state", {30'd0, dbg_state}, {30'd0, MUL});
    bus.op_valid = 1'b1; bus.alu_op = 3'd0; bus.wb_sel = 2'b10; bus.imm = 8'h55;
    bus.W_addr = 4'd10; bus.W_wr = 1'b1;
    step(16);
    check("mul_done17", {31'd0, done}, 32'd1);
    check("mul_ready17", {31'd0, bus.op_ready}, 32'd0);
    check_reg("mul_r6_17", 4'd6, 16'h0000);
    check_reg("held_r10_17", 4'd10, 16'h0000);
    step(1);
    check("mul_done18", {31'd0, done}, 32'd0);
    check("mul_ready18", {31'd0, bus.op_ready}, 32'd1);
    check_reg("mul_r6", 4'd6, 16'h03A8);
    check("mul_flags", {28'd0, flags}, 32'h0);
    step(1);
    bus.op_valid = 1'b0; bus.W_wr = 1'b0;
    check_reg("held_r10", 4'd10, 16'h0055);

    // MUL 0x0100 * 0x0100 overflows into the high half
    issue(3'd0, 2'b01, 4'd11, 1'b1, 4'd0, 4'd0, 8'h00, 16'h0100);
    issue(3'd0, 2'b01, 4'd13, 1'b1, 4'd0, 4'd0, 8'h00, 16'h1234);
    issue(3'b111, 2'b00, 4'd13, 1'b1, 4'd11, 4'd11, 8'h00, 16'h0);
    step(17);
    check_reg("mul2_r13", 4'd13, 16'h0000);
    check("mul2_flags", {28'd0, flags}, 32'hA);

    // reset in cycle 8 of a MUL
    issue(3'b111, 2'b00, 4'd14, 1'b1, 4'd4, 4'd5, 8'h00, 16'h0);
    step(7);
    rst = 1'b0;
    #1;
    check("mrst_state", {30'd0, dbg_state}, {30'd0, IDLE});
    check("mrst_ready", {31'd0, bus.op_ready}, 32'd1);
    check("mrst_done", {31'd0, done}, 32'd0);
    step(1);
    rst = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (done) done_seen++;
    end
    check("mrst_nodone", done_seen, 32'd0);
    check_reg("mrst_r14", 4'd14, 16'h0000);
    check_reg("mrst_r4", 4'd4, 16'h0000);
    check("mrst_rpzero", {31'd0, Rp_zero}, 32'd1);
    check("mrst_flags", {28'd0, flags}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
